// File: rtl/byte_frame_packer.sv
// byte_frame_packer: packs a byte stream into 3-element frames with an assembly buffer and a registered output stage.
module byte_frame_packer #(
    parameter int W = 8,
    parameter int N = 3,
    parameter logic [W-1:0] PAD = 8'h00
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         sig_a,
    input  logic         sig_ready,
    output logic [W-1:0] sig_d [N],
    output logic [1:0]   sig_b,
    output logic [1:0]   sig_cnt
);
    logic [W-1:0] asm_d [N];
    logic [W-1:0] nxt [N];
    logic [1:0] idx, seq;
    logic pending, accept, complete, out_free, load_new, load_pend;
    always_comb begin
        in_ready  = !rst && !pending;
        accept    = in_valid && in_ready;
        complete  = accept && (in_last || idx == 2'(N - 1));
        out_free  = !sig_a || sig_ready;
        load_new  = complete && out_free;
        load_pend = pending && sig_a && sig_ready;
        // current frame with the incoming byte in slot idx and padding above it
        for (int i = 0; i < N; i++)
            nxt[i] = 2'(i) < idx ? asm_d[i] : 2'(i) == idx ? in_data : PAD;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            seq     <= '0;
            pending <= 1'b0;
            sig_a   <= 1'b0;
            sig_b   <= '0;
            sig_cnt <= '0;
            for (int i = 0; i < N; i++) begin
                sig_d[i] <= PAD;
                asm_d[i] <= PAD;
            end
        end else begin
            if (accept)
                asm_d <= nxt;
            if (load_new || load_pend)
                idx <= '0;
            else if (accept && !complete)
                idx <= idx + 2'd1;
            if (complete && !out_free)
                pending <= 1'b1;
            else if (load_pend)
                pending <= 1'b0;
            if (load_new || load_pend) begin
                sig_a   <= 1'b1;
                sig_b   <= seq;
                sig_cnt <= idx + 2'd1;
                seq     <= seq + 2'd1;
                for (int i = 0; i < N; i++)
                    sig_d[i] <= load_new ? nxt[i] : asm_d[i];
            end else if (sig_ready) begin
                sig_a <= 1'b0;
            end
        end
    end
endmodule

// File: doc/byte_frame_packer.md
# byte_frame_packer

Upstream stage of the `sub1` datapath: collects a byte stream into fixed three-element frames and drives `sub1`'s `sig_a` (frame valid) and `sig_d` (`[7:0]` × `[3]` frame array) inputs. Each frame carries a 2-bit sequence tag on `sig_b` and a byte count on `sig_cnt`. A completed frame is double-buffered (assembly register plus output register), so input keeps streaming while downstream applies backpressure.

## Interface
- `W`, default 8: byte width.
- `N`, default 3: elements per frame. Fixed at 3 for this release; `sig_cnt` and `sig_b` widths assume it.
- `PAD`, default `8'h00`: fill value for unused elements of a short frame.

Ports (direction, width, meaning):
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: input byte valid.
- `in_ready`, out, 1: packer accepts a byte this cycle.
- `in_data`, in, `W`: input byte. Ignored when `!in_valid`.
- `in_last`, in, 1: this byte closes the frame early. Qualified by `in_valid`.
- `sig_a`, out, 1: output frame valid.
- `sig_ready`, in, 1: downstream accepts the frame.
- `sig_d`, out, `[W-1:0]` × `[N]` unpacked: frame data. Element 0 holds the first byte.
- `sig_b`, out, 2: frame sequence number, modulo 4.
- `sig_cnt`, out, 2: number of real bytes in the frame (1..3).

## Operation
- **Input accept:** a byte is accepted when `in_valid && in_ready`. It is written to assembly slot `idx` (0..2), and `idx` increments.
- **Frame completion:** a frame completes on an accepted byte with `idx == 2` or `in_last == 1`.
  - Slots above the completing index read as `PAD`.
  - The byte count is the completing index + 1.
- **Output register state:** EMPTY (`sig_a = 0`) or FULL (`sig_a = 1`). The output frees in a cycle when it is EMPTY or `sig_a && sig_ready`.
- **Completing byte, output frees this cycle:** the frame (including the completing byte) loads straight into the output register at that edge.
  - `sig_b` takes the current sequence counter value; the counter then increments.
  - `idx` resets to 0.
- **Completing byte, output does not free:** the frame parks in assembly and `pending` is set. `in_ready = !pending`.
- **Pending frame moves:** while `pending`, the first cycle with `sig_a && sig_ready` loads the assembly frame into the output register on that edge. `pending` clears and `idx` resets to 0.
- **Output drain:** when `sig_a && sig_ready` and nothing loads, the output goes EMPTY.
- **Output stability:** `sig_d`, `sig_b` and `sig_cnt` are stable while `sig_a && !sig_ready`.
- **`in_last` on slot 0:** produces `sig_cnt = 1` with elements 1 and 2 equal to `PAD`.
- **Frame order:** frames are never dropped or reordered. At most 2 frames are in flight (output + pending).
- **Reset values** (while `rst` is high and on the cycle after):
  - `sig_a = 0`, `in_ready = 0` while `rst` is high, then 1 from the first cycle after `rst` falls.
  - `sig_d` = all `PAD`, `sig_b = 0`, `sig_cnt = 0`.
  - `idx = 0`, `pending = 0`, sequence counter = 0.
- **Reset mid-operation:** discards any partial, pending and output frame, and restarts numbering at 0.

## Timing
- **Latency:** a completing byte accepted at edge k, with the output free, gives `sig_a = 1` in the cycle after edge k.
- **Throughput:** with `sig_ready` held high, `in_ready` stays 1 continuously. Sustained rate is one byte per cycle and one frame per 3 cycles.
- **Pending release:** `in_ready` falls in the cycle after the edge that sets `pending`. It rises in the cycle after the edge where the pending frame moves to the output.
- **Same-cycle accept and complete:** downstream accept of frame F and completion of frame F+1 in the same cycle load F+1 at that edge, with no bubble and no pending.
- **Sequence wrap:** 3 → 0.
- **Combinational paths:** `in_ready` has no combinational path from `sig_ready`; it is registered state only.

## Test plan
- **Basic frame:** `sig_ready = 1`; send `11`, `22`, `33` back-to-back → one cycle after the 3rd accept, `sig_a = 1` for one cycle with `sig_d = {11,22,33}`, `sig_cnt = 3`, `sig_b = 0`.
- **Short frame:** send `AA`, then `BB` with `in_last = 1` → `sig_d = {AA,BB,00}`, `sig_cnt = 2`. Then `CC` with `in_last = 1` → `{CC,00,00}`, `sig_cnt = 1`, `sig_b = 1`.
- **Backpressure:** `sig_ready = 0`; offer 7 bytes `01`..`07` continuously.
  - `in_ready` falls after `06` is accepted, and `07` stalls.
  - Raise `sig_ready` → frames `{01,02,03}` (`sig_b = 0`) then `{04,05,06}` (`sig_b = 1`).
  - `in_ready` rises the cycle after the second frame loads, and `07` is accepted.
  - Outputs are stable throughout the stall.
- **Streaming:** 15 bytes, `in_valid = 1` every cycle, `sig_ready = 1` → `in_ready` never low; 5 frames spaced 3 cycles apart with `sig_b` = 0, 1, 2, 3, 0.
- **Reset mid-frame:** accept `A1`, `A2`, then assert `rst` for 1 cycle → `sig_a = 0` and `sig_d` all `PAD`. The next `B1`, `B2`, `B3` give `{B1,B2,B3}` with `sig_b = 0`.
- **Reset with pending frame:** set up a FULL output plus a pending frame, then assert `rst` → both discarded, `in_ready = 1` the cycle after `rst` falls, and no stale frame ever appears on `sig_a`.
